// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the boot-time program loader:
//   - loader FSM state encoding
//   - frame header byte and the NOP used to pad unused instruction slots
//   - default memory geometry (matches the RISC_16 4-bit instruction_addr)
//   - byte_ready decode helper shared by the loader FSM
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam int ADDR_W_DEF  = 4;
  localparam int DEPTH_DEF   = 16;
  localparam int INSTR_W_DEF = 16;

  localparam logic [7:0]  HEADER    = 8'hA5;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SYNC  = 4'd1,
    ST_COUNT = 4'd2,
    ST_HI    = 4'd3,
    ST_LO    = 4'd4,
    ST_CHECK = 4'd5,
    ST_PAD   = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERROR = 4'd8
  } state_e;

  // States in which the loader consumes a stream byte.
  function automatic logic accepts_byte(input state_e s);
    logic r;
    case (s)
      ST_SYNC, ST_COUNT, ST_HI, ST_LO, ST_CHECK: r = 1'b1;
      default:                                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// -----------------------------------------------------------------------------
// loader_checksum
// 8-bit modulo-256 running sum over the frame bytes after the header.
// Ports:
//   clk, rst     clock and synchronous active-low reset
//   clr          restart the sum (combined with add_en it loads add_data)
//   add_en       accumulate add_data this cycle
//   add_data     byte to accumulate
//   cmp_data     byte compared against the current registered sum
//   match        cmp_data == sum (combinational, for the CHECK byte)
// -----------------------------------------------------------------------------
module loader_checksum
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add_en,
  input  logic [7:0] add_data,
  input  logic [7:0] cmp_data,
  output logic       match
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;
  logic [7:0] base_s;

  // Next sum: optional clear, then optional add; carry out is dropped.
  always_comb begin
    base_s = sum_q;
    sum_d  = sum_q;
    if (clr) begin
      base_s = 8'h00;
    end else begin
      base_s = sum_q;
    end
    if (add_en) begin
      sum_d = base_s + add_data;
    end else begin
      sum_d = base_s;
    end
  end

  // Sum register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match = (cmp_data == sum_q);

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Boot-time loader in front of the RISC_16 core. Receives a framed program
// (A5, N, N x {hi,lo}, CSUM) over a valid/ready byte stream, writes the
// instructions into instruction memory, pads the remaining slots with NOP and
// releases the core reset only once a checksum-verified image is resident.
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   start                       level request to (re)start a load
//   byte_valid/byte_data        incoming byte stream
//   byte_ready                  loader will take a byte this cycle
//   imem_we/imem_waddr/wdata    registered one-cycle instruction-memory write
//   cpu_rst                     active-high reset to the core (low only in DONE)
//   load_done / load_error      status, high only in DONE / ERROR
// -----------------------------------------------------------------------------
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               load_error
);

  // idx and n carry one extra bit so that N == DEPTH is representable.
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] IDX_FULL = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W:0]     n_q, n_d;
  logic [7:0]          hi_q, hi_d;
  logic                byte_ready_q, byte_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
  logic [INSTR_W-1:0]  imem_wdata_q, imem_wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;

  logic                xfer_s;
  logic                n_illegal_s;
  logic [ADDR_W:0]     idx_inc_s;
  logic                cs_clr_s;
  logic                cs_add_s;
  logic                cs_match_s;

  assign xfer_s      = byte_valid & byte_ready_q;
  assign n_illegal_s = (byte_data == 8'h00) || (int'(byte_data) > DEPTH);
  assign idx_inc_s   = idx_q + IDX_ONE;

  loader_checksum u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clr      (cs_clr_s),
    .add_en   (cs_add_s),
    .add_data (byte_data),
    .cmp_data (byte_data),
    .match    (cs_match_s)
  );

  // Loader FSM: next state, index/hi-byte updates, write request and checksum control.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_d          = n_q;
    hi_d         = hi_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    cs_clr_s     = 1'b0;
    cs_add_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SYNC: begin
        // Anything other than the header is silently dropped while hunting.
        if (xfer_s && (byte_data == HEADER)) begin
          state_d = ST_COUNT;
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_COUNT: begin
        if (xfer_s) begin
          if (n_illegal_s) begin
            state_d = ST_ERROR;
          end else begin
            n_d      = byte_data[ADDR_W:0];
            idx_d    = '0;
            cs_clr_s = 1'b1;
            cs_add_s = 1'b1;
            state_d  = ST_HI;
          end
        end else begin
          state_d = ST_COUNT;
        end
      end

      ST_HI: begin
        if (xfer_s) begin
          hi_d     = byte_data;
          cs_add_s = 1'b1;
          state_d  = ST_LO;
        end else begin
          state_d = ST_HI;
        end
      end

      ST_LO: begin
        if (xfer_s) begin
          imem_we_d    = 1'b1;
          imem_waddr_d = idx_q[ADDR_W-1:0];
          imem_wdata_d = {hi_q, byte_data};
          cs_add_s     = 1'b1;
          idx_d        = idx_inc_s;
          if (idx_inc_s == n_q) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_HI;
          end
        end else begin
          state_d = ST_LO;
        end
      end

      ST_CHECK: begin
        // The checksum byte is compared as it arrives, not after registering.
        if (xfer_s) begin
          if (cs_match_s) begin
            if (n_q < IDX_FULL) begin
              state_d = ST_PAD;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_PAD: begin
        imem_we_d    = 1'b1;
        imem_waddr_d = idx_q[ADDR_W-1:0];
        imem_wdata_d = NOP_INSTR;
        idx_d        = idx_inc_s;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PAD;
        end
      end

      ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_SYNC;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status and handshake outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    byte_ready_d = accepts_byte(state_d);
    cpu_rst_d    = (state_d != ST_DONE);
    load_done_d  = (state_d == ST_DONE);
    load_error_d = (state_d == ST_ERROR);
  end

  // State, datapath and registered output flops; reset cancels any pending write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      hi_q         <= 8'h00;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      hi_q         <= hi_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Scoreboard bench for program_loader. Stimulus pushes every expected
// instruction-memory write into exp_q before the bytes that cause it are sent;
// a free-running monitor pops and compares on every imem_we strobe.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [3:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        cpu_rst;
  logic        load_done;
  logic        load_error;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] prog[$];
  int          checks = 0;
  int          errors = 0;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, required no write", imem_waddr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL imem_write: got addr=%0h data=%04h, required addr=%0h data=%04h",
                   imem_waddr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                              input logic exp_cpu_rst);
    check({name, "_load_done"}, 32'(load_done), 32'(exp_done));
    check({name, "_load_error"}, 32'(load_error), 32'(exp_err));
    check({name, "_cpu_rst"}, 32'(cpu_rst), 32'(exp_cpu_rst));
  endtask

  // Present one byte with random leading idle cycles; returns at the negedge after it transferred.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while ($urandom_range(0, 2) == 0) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got ready=0 for byte %02h, required ready=1", b);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Frame from prog[]; expectations for payload (and pad when pad_ok) are queued first.
  task automatic send_frame(input logic [7:0] csum, input bit pad_ok);
    send_byte(8'hA5);
    send_byte(8'(prog.size()));
    foreach (prog[i]) begin
      exp_q.push_back({4'(i), prog[i]});
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
    end
    if (pad_ok) begin
      for (int j = prog.size(); j < 16; j++) begin
        exp_q.push_back({4'(j), 16'h0000});
      end
    end
    send_byte(csum);
  endtask

  function automatic logic [7:0] csum_of();
    logic [7:0] s;
    s = 8'(prog.size());
    foreach (prog[i]) begin
      s = s + prog[i][15:8] + prog[i][7:0];
    end
    return s;
  endfunction

  // Wait (bounded) for DONE or ERROR, then one more cycle so the monitor drains.
  task automatic wait_end(input string name);
    int guard;
    guard = 0;
    while (!(load_done || load_error) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!(load_done || load_error)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done/error, required done or error", name);
    end
    @(negedge clk);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_waddr", 32'(imem_waddr), 32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Good 3-instruction load; sum = 03+12+34+56+78+9A+BC = 0x26D -> 6D.
    pulse_start();
    check("sync_byte_ready", 32'(byte_ready), 32'd1);
    prog = '{16'h1234, 16'h5678, 16'h9ABC};
    send_frame(8'h6D, 1'b1);
    wait_end("good3");
    check_status("good3", 1'b1, 1'b0, 1'b0);
    check("done_byte_ready", 32'(byte_ready), 32'd0);

    // Restart from DONE: cpu_rst reasserts with the start edge.
    pulse_start();
    check_status("restart", 1'b0, 1'b0, 1'b1);

    // Bad checksum: writes for payload happen, no pad.
    send_frame(8'h6E, 1'b0);
    wait_end("badcsum");
    check_status("badcsum", 1'b0, 1'b1, 1'b1);

    // Full 16-entry image, no pad writes.
    pulse_start();
    prog.delete();
    for (int i = 0; i < 16; i++) begin
      prog.push_back({8'(8'h10 + i), 8'(8'hE0 - 3 * i)});
    end
    send_frame(csum_of(), 1'b1);
    wait_end("full16");
    check_status("full16", 1'b1, 1'b0, 1'b0);

    // Junk before header: 00, FF dropped; then A5,01,00,01,02.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'hFF);
    prog = '{16'h0001};
    send_frame(8'h02, 1'b1);
    wait_end("junk");
    check_status("junk", 1'b1, 1'b0, 1'b0);

    // Illegal N = 0.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h00);
    wait_end("n00");
    check_status("n00", 1'b0, 1'b1, 1'b1);

    // Illegal N = 17.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h11);
    wait_end("n11");
    check_status("n11", 1'b0, 1'b1, 1'b1);

    // Reset after the 2nd LO byte: its write is already out, nothing follows.
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h03);
    exp_q.push_back({4'd0, 16'h1234});
    send_byte(8'h12);
    send_byte(8'h34);
    exp_q.push_back({4'd1, 16'h5678});
    send_byte(8'h56);
    send_byte(8'h78);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_status("midrst", 1'b0, 1'b0, 1'b1);
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_imem_we", 32'(imem_we), 32'd0);
    byte_valid = 1'b1;
    byte_data  = 8'h9A;
    repeat (4) @(negedge clk);
    byte_valid = 1'b0;
    check("midrst_pending_writes", 32'(exp_q.size()), 32'd0);

    // Reload after the interrupted frame.
    pulse_start();
    prog = '{16'h1234, 16'h5678, 16'h9ABC};
    send_frame(8'h6D, 1'b1);
    wait_end("reload");
    check_status("reload", 1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
